// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Sequencing controller for the 5-stage LEGv8 pipeline. It handles three jobs:
//   * load-use hazards: holds PC and IF/ID for LOAD_LAT cycles and bubbles ID/EX
//   * taken branches resolved in MEM: flushes IF/ID, ID/EX and EX/MEM
//   * data-memory wait states: freezes the whole pipeline, with a watchdog
//
// Parameters
//   LOAD_LAT       stall cycles per load-use hazard (>= 1)
//   STALL_TIMEOUT  consecutive dmem-not-ready cycles before timeout_err (0 = off)
//
// Optional feature macro: HAZARD_PERF_EN
//   defined   -> 32-bit stall_count / flush_count performance counters
//   undefined -> no counter flops, both outputs tie to zero
//
// Ports
//   clk             in   clock, all state on rising edge
//   reset           in   synchronous reset, active-high
//   ID_EX_memRead   in   instruction in EX is a load
//   ID_EX_rd        in   destination register of instruction in EX
//   IF_ID_rn/rm     in   source registers of instruction in ID
//   branch_taken_M  in   taken branch resolved in MEM
//   dmem_ready      in   data memory completes its access this cycle
//   PC_write        out  PC load enable
//   IF_ID_write     out  IF/ID load enable
//   ID_EX_bubble    out  zero control bits entering ID/EX
//   IF_ID_flush     out  clear IF/ID
//   ID_EX_flush     out  clear ID/EX
//   EX_MEM_flush    out  clear EX/MEM
//   pipe_en         out  load enable for ID/EX, EX/MEM, MEM/WB
//   timeout_err     out  sticky watchdog flag
//   stall_count     out  load-use stall cycles (perf)
//   flush_count     out  branch flush events (perf)
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int LOAD_LAT      = 1,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_EX_memRead,
  input  logic [4:0]  ID_EX_rd,
  input  logic [4:0]  IF_ID_rn,
  input  logic [4:0]  IF_ID_rm,
  input  logic        branch_taken_M,
  input  logic        dmem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        EX_MEM_flush,
  output logic        pipe_en,
  output logic        timeout_err,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam int LCW = $clog2(LOAD_LAT + 1);
  localparam int WW  = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [LCW-1:0] LCNT_INIT = LCW'(LOAD_LAT - 1);
  localparam logic [WW-1:0]  W_LIMIT   = WW'(STALL_TIMEOUT);

  typedef enum logic [0:0] {RUN, LOAD_STALL} state_t;

  state_t          r_state;
  logic [LCW-1:0]  r_lcnt;
  logic [WW-1:0]   r_wcnt;
  logic            r_timeout;

  logic            w_haz;
  logic            w_flush;
  logic            w_ld_stall;
  logic [WW-1:0]   w_wcnt_inc;

  // XZR (X31) is never a real producer, so it cannot create a hazard.
  assign w_haz = ID_EX_memRead && (ID_EX_rd != 5'd31) &&
                 ((ID_EX_rd == IF_ID_rn) || (ID_EX_rd == IF_ID_rm));

  // Branch_taken_M is held by the frozen MEM stage during a dmem wait, so
  // gating it with dmem_ready defers the flush to the first ready cycle.
  assign w_flush    = dmem_ready && branch_taken_M;
  assign w_ld_stall = dmem_ready && !branch_taken_M &&
                      ((r_state == LOAD_STALL) || ((r_state == RUN) && w_haz));
  assign w_wcnt_inc = r_wcnt + WW'(1);

  // Output decode, priority: reset > dmem freeze > branch flush > load-use > idle.
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    pipe_en      = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    if (reset) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      pipe_en      = 1'b0;
      ID_EX_bubble = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (!dmem_ready) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_en     = 1'b0;
    end else if (w_flush) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (w_ld_stall) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  assign timeout_err = r_timeout;

  // FSM, load-stall down-counter and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_lcnt    <= '0;
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      // Watchdog: count consecutive wait cycles, saturating at the limit.
      if (!dmem_ready) begin
        if ((STALL_TIMEOUT != 0) && (r_wcnt != W_LIMIT)) begin
          r_wcnt <= w_wcnt_inc;
          if (w_wcnt_inc == W_LIMIT) begin
            r_timeout <= 1'b1;
          end
        end
      end else begin
        r_wcnt <= '0;
      end

      // State and lcnt hold while memory is not ready.
      if (w_flush) begin
        r_state <= RUN;
        r_lcnt  <= '0;
      end else if (dmem_ready) begin
        case (r_state)
          RUN: begin
            // With LOAD_LAT==1 the single bubble is enough; stay in RUN.
            if (w_haz && (LOAD_LAT > 1)) begin
              r_state <= LOAD_STALL;
              r_lcnt  <= LCNT_INIT;
            end
          end
          LOAD_STALL: begin
            r_lcnt <= r_lcnt - LCW'(1);
            if (r_lcnt == LCW'(1)) begin
              r_state <= RUN;
            end
          end
          default: begin
            r_state <= RUN;
            r_lcnt  <= '0;
          end
        endcase
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  // Both qualifiers already require dmem_ready, so counts hold during a freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_ld_stall) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (w_flush) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Directed bench for hazard_controller. Two instances share one input set:
//   dut_a : LOAD_LAT=1, STALL_TIMEOUT=255
//   dut_b : LOAD_LAT=3, STALL_TIMEOUT=4
// Each step drives inputs just after a falling edge and checks the
// combinational outputs 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       mr;
  logic [4:0] rd, rn, rm;
  logic       br;
  logic       dr;

  logic        a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_pen, a_to;
  logic [31:0] a_sc, a_fc;
  logic        b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_pen, b_to;
  logic [31:0] b_sc, b_fc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_LAT(1), .STALL_TIMEOUT(255)) dut_a (
    .clk(clk), .reset(rst), .ID_EX_memRead(mr), .ID_EX_rd(rd),
    .IF_ID_rn(rn), .IF_ID_rm(rm), .branch_taken_M(br), .dmem_ready(dr),
    .PC_write(a_pcw), .IF_ID_write(a_ifw), .ID_EX_bubble(a_bub),
    .IF_ID_flush(a_iff), .ID_EX_flush(a_idf), .EX_MEM_flush(a_exf),
    .pipe_en(a_pen), .timeout_err(a_to), .stall_count(a_sc), .flush_count(a_fc)
  );

  hazard_controller #(.LOAD_LAT(3), .STALL_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(rst), .ID_EX_memRead(mr), .ID_EX_rd(rd),
    .IF_ID_rn(rn), .IF_ID_rm(rm), .branch_taken_M(br), .dmem_ready(dr),
    .PC_write(b_pcw), .IF_ID_write(b_ifw), .ID_EX_bubble(b_bub),
    .IF_ID_flush(b_iff), .ID_EX_flush(b_idf), .EX_MEM_flush(b_exf),
    .pipe_en(b_pen), .timeout_err(b_to), .stall_count(b_sc), .flush_count(b_fc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the falling edge, apply one input vector, settle 1 ns.
  task automatic drive(input string name, input logic r, input logic m,
                       input logic [4:0] d, input logic [4:0] n, input logic [4:0] s,
                       input logic b, input logic rdy);
    @(negedge clk);
    rst = r; mr = m; rd = d; rn = n; rm = s; br = b; dr = rdy;
    #1;
    $display("t=%0t step %s rst=%0b mr=%0b rd=%0d rn=%0d rm=%0d br=%0b dr=%0b",
             $time, name, r, m, d, n, s, b, rdy);
  endtask

  task automatic idle(input string name);
    drive(name, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    drive("reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset cycle outputs come straight from reset.
    rst = 1'b1; mr = 1'b0; rd = 5'd0; rn = 5'd0; rm = 5'd0; br = 1'b0; dr = 1'b1;
    #1;
    check("rst_pcw",   {31'd0, a_pcw}, 32'd0);
    check("rst_ifw",   {31'd0, a_ifw}, 32'd0);
    check("rst_pen",   {31'd0, a_pen}, 32'd0);
    check("rst_bub",   {31'd0, a_bub}, 32'd1);
    check("rst_iff",   {31'd0, a_iff}, 32'd1);
    check("rst_idf",   {31'd0, b_idf}, 32'd1);
    check("rst_exf",   {31'd0, b_exf}, 32'd1);

    idle("idle");
    check("idle_pcw",  {31'd0, a_pcw}, 32'd1);
    check("idle_pen",  {31'd0, a_pen}, 32'd1);
    check("idle_bub",  {31'd0, b_bub}, 32'd0);
    check("idle_iff",  {31'd0, b_iff}, 32'd0);
    check("idle_to",   {31'd0, b_to},  32'd0);
    check("idle_sc",   a_sc, 32'd0);
    check("idle_fc",   b_fc, 32'd0);

    // No-hazard patterns.
    drive("xzr", 1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1);
    check("xzr_pcw",   {31'd0, a_pcw}, 32'd1);
    check("xzr_bub",   {31'd0, b_bub}, 32'd0);
    drive("nomatch", 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1);
    check("nomatch_bub", {31'd0, a_bub}, 32'd0);
    drive("noload", 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1);
    check("noload_pcw", {31'd0, a_pcw}, 32'd1);

    // LOAD_LAT=1 hazard via rm, then the bubble removes the load from EX.
    drive("haz_rm", 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    check("a1_pcw",    {31'd0, a_pcw}, 32'd0);
    check("a1_ifw",    {31'd0, a_ifw}, 32'd0);
    check("a1_bub",    {31'd0, a_bub}, 32'd1);
    check("a1_pen",    {31'd0, a_pen}, 32'd1);
    idle("after_a1");
    check("a1_next_pcw", {31'd0, a_pcw}, 32'd1);
    check("a1_next_bub", {31'd0, a_bub}, 32'd0);
    check("a1_sc",     a_sc, PERF * 1);
    check("b_in_stall", {31'd0, b_bub}, 32'd1);

    // LOAD_LAT=3 hazard via rn: exactly three stall cycles.
    do_reset();
    drive("haz_rn", 1'b0, 1'b1, 5'd1, 5'd1, 5'd2, 1'b0, 1'b1);
    check("b1_bub",    {31'd0, b_bub}, 32'd1);
    check("b1_pcw",    {31'd0, b_pcw}, 32'd0);
    idle("b_stall2");
    check("b2_bub",    {31'd0, b_bub}, 32'd1);
    check("b2_ifw",    {31'd0, b_ifw}, 32'd0);
    idle("b_stall3");
    check("b3_bub",    {31'd0, b_bub}, 32'd1);
    idle("b_done");
    check("b4_bub",    {31'd0, b_bub}, 32'd0);
    check("b4_pcw",    {31'd0, b_pcw}, 32'd1);
    check("b4_sc",     b_sc, PERF * 3);

    // Branch in the 2nd stall cycle discards the remaining stall.
    do_reset();
    drive("haz_br", 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1);
    check("br1_bub",   {31'd0, b_bub}, 32'd1);
    drive("branch", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    check("br_iff",    {31'd0, b_iff}, 32'd1);
    check("br_idf",    {31'd0, b_idf}, 32'd1);
    check("br_exf",    {31'd0, b_exf}, 32'd1);
    check("br_pcw",    {31'd0, b_pcw}, 32'd1);
    check("br_bub",    {31'd0, b_bub}, 32'd0);
    idle("after_br");
    check("abr_pcw",   {31'd0, b_pcw}, 32'd1);
    check("abr_bub",   {31'd0, b_bub}, 32'd0);
    check("abr_iff",   {31'd0, b_iff}, 32'd0);
    check("abr_fc",    b_fc, PERF * 1);
    check("abr_sc",    b_sc, PERF * 1);

    // Freeze inside a load stall holds the FSM and the stall counter.
    do_reset();
    drive("haz_frz", 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1);
    check("fz1_bub",   {31'd0, b_bub}, 32'd1);
    drive("frz1", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("fz2_bub",   {31'd0, b_bub}, 32'd0);
    check("fz2_pen",   {31'd0, b_pen}, 32'd0);
    check("fz2_pcw",   {31'd0, b_pcw}, 32'd0);
    drive("frz2", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("fz3_pen",   {31'd0, b_pen}, 32'd0);
    idle("unfrz1");
    check("fz4_bub",   {31'd0, b_bub}, 32'd1);
    idle("unfrz2");
    check("fz5_bub",   {31'd0, b_bub}, 32'd1);
    idle("unfrz3");
    check("fz6_bub",   {31'd0, b_bub}, 32'd0);
    check("fz6_sc",    b_sc, PERF * 3);

    // Branch held during a 4-cycle freeze is acted on in the 5th cycle.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive("frz_br", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      check($sformatf("fb%0d_pen", i), {31'd0, b_pen}, 32'd0);
      check($sformatf("fb%0d_iff", i), {31'd0, b_iff}, 32'd0);
      check($sformatf("fb%0d_to", i),  {31'd0, b_to},  32'd0);
    end
    drive("frz_br_go", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    check("fb5_iff",   {31'd0, b_iff}, 32'd1);
    check("fb5_exf",   {31'd0, b_exf}, 32'd1);
    check("fb5_pcw",   {31'd0, b_pcw}, 32'd1);
    check("fb5_to_b",  {31'd0, b_to},  32'd1);
    check("fb5_to_a",  {31'd0, a_to},  32'd0);

    // Watchdog: timeout_err from the 5th frozen cycle, sticky until reset.
    do_reset();
    idle("wd_idle");
    check("wd_clr",    {31'd0, b_to}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      drive("wd_frz", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      check($sformatf("wd%0d_to", i),  {31'd0, b_to},  (i >= 5) ? 32'd1 : 32'd0);
      check($sformatf("wd%0d_pen", i), {31'd0, b_pen}, 32'd0);
    end
    idle("wd_ready1");
    check("wd_rdy_to",  {31'd0, b_to},  32'd1);
    check("wd_rdy_pen", {31'd0, b_pen}, 32'd1);
    idle("wd_ready2");
    check("wd_rdy2_to", {31'd0, b_to},  32'd1);
    do_reset();
    idle("wd_after_rst");
    check("wd_rst_to",  {31'd0, b_to},  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
